result_uart_tx: RTL and testbench

//   Takes the solver's final 64-bit result (total presses) and its done flag, converts the value
//   to ASCII decimal and transmits it once over a UART line as "<digits>\r\n".

---
 rtl/aoc_uart_pkg.sv | 21 ++
 rtl/uart_tx_byte.sv | 62 ++++++
 rtl/result_uart_tx.sv | 131 +++++++++++++
 tb/tb_result_uart_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/aoc_uart_pkg.sv
// Shared constants and reporter FSM encoding for the per-day UART result reporters.
package aoc_uart_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // 100 MHz system clock at 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CONVERT  = 3'd1,
        ST_SKIPZ    = 3'd2,
        ST_SEND_DIG = 3'd3,
        ST_SEND_CR  = 3'd4,
        ST_SEND_LF  = 3'd5,
        ST_FINISH   = 3'd6
    } report_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// Generic 8N1 serialiser: start bit, data LSB first, stop bit, each CLKS_PER_BIT clocks.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       load,
    output logic       ready,
    output logic       tx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic              active;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              stop_end;

    // bit_cnt names the bit currently on the line: 0 start, 1..8 data, 9 stop.
    assign stop_end = active && (bit_cnt == 4'd9) && (baud_cnt == BAUD_LAST);
    // Ready in the last stop-bit cycle lets the next start bit follow with no idle gap.
    assign ready    = !active || stop_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
        end else if (load && ready) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            active   <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= data;
            tx       <= 1'b0;
        end else if (active) begin
            if (baud_cnt == BAUD_LAST) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd8) begin
                        tx <= 1'b1;
                    end else begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/result_uart_tx.sv
// Converts the solver's final binary result to ASCII decimal and sends it once as "<digits>\r\n".
module result_uart_tx
    import aoc_uart_pkg::*;
#(
    parameter int RESULT_W     = 64,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int NDIGITS      = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [RESULT_W-1:0] result,
    input  logic                result_valid,
    output logic                tx,
    output logic                busy,
    output logic                sent
);

    localparam int DIG_W = $clog2(NDIGITS);
    localparam int CNT_W = $clog2(RESULT_W);

    report_state_e         state, next_state;
    logic                  prev_valid;
    logic                  trigger;
    logic [RESULT_W-1:0]   value;
    logic [4*NDIGITS-1:0]  bcd, bcd_adj;
    logic [CNT_W-1:0]      conv_cnt;
    logic [DIG_W-1:0]      dig_idx;
    logic [3:0]            cur_digit;
    logic                  lf_loaded;
    logic                  load, ready;
    logic [7:0]            tx_data;

    assign trigger   = result_valid && !prev_valid;
    assign cur_digit = bcd[4*dig_idx +: 4];
    assign busy      = (state != ST_IDLE) && (state != ST_FINISH);
    assign sent      = (state == ST_FINISH);

    // Double-dabble correction: any digit >= 5 would overflow past 9 once doubled.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        bcd_adj = bcd;
        for (int i = 0; i < NDIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        tx_data    = 8'h00;
        case (state)
            ST_IDLE:    if (trigger) next_state = ST_CONVERT;
            ST_CONVERT: if (conv_cnt == CNT_W'(RESULT_W - 1)) next_state = ST_SKIPZ;
            ST_SKIPZ:   if (cur_digit != 4'd0 || dig_idx == '0) next_state = ST_SEND_DIG;
            ST_SEND_DIG: begin
                tx_data = ASCII_ZERO + {4'd0, cur_digit};
                load    = ready;
                if (ready && dig_idx == '0) next_state = ST_SEND_CR;
            end
            ST_SEND_CR: begin
                tx_data = ASCII_CR;
                load    = ready;
                if (ready) next_state = ST_SEND_LF;
            end
            ST_SEND_LF: begin
                tx_data = ASCII_LF;
                // Once LF is handed over, ready returning marks the end of its stop bit.
                if (!lf_loaded)  load       = ready;
                else if (ready)  next_state = ST_FINISH;
            end
            ST_FINISH:  next_state = ST_FINISH;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            value      <= '0;
            bcd        <= '0;
            conv_cnt   <= '0;
            dig_idx    <= '0;
            lf_loaded  <= 1'b0;
        end else begin
            prev_valid <= result_valid;
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        value     <= result;
                        bcd       <= '0;
                        conv_cnt  <= '0;
                        lf_loaded <= 1'b0;
                    end
                end
                ST_CONVERT: begin
                    bcd      <= {bcd_adj[4*NDIGITS-2:0], value[RESULT_W-1]};
                    value    <= value << 1;
                    conv_cnt <= conv_cnt + 1'b1;
                    if (conv_cnt == CNT_W'(RESULT_W - 1)) dig_idx <= DIG_W'(NDIGITS - 1);
                end
                ST_SKIPZ: begin
                    if (cur_digit == 4'd0 && dig_idx != '0) dig_idx <= dig_idx - 1'b1;
                end
                ST_SEND_DIG: begin
                    if (ready && dig_idx != '0) dig_idx <= dig_idx - 1'b1;
                end
                ST_SEND_LF: begin
                    if (load) lf_loaded <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (tx_data),
        .load  (load),
        .ready (ready),
        .tx    (tx)
    );

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: a mid-bit UART receiver collects bytes and compares them with a decimal-print model.
module tb_result_uart_tx;

    localparam int CPB   = 4;
    localparam int RW    = 64;
    localparam int ND    = 20;
    localparam int FRAME = 10 * CPB;
    localparam int MAX_LAT = RW + ND + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RW-1:0] result = '0;
    logic          result_valid = 1'b0;
    logic          tx, busy, sent;

    result_uart_tx #(.RESULT_W(RW), .CLKS_PER_BIT(CPB), .NDIGITS(ND)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .result       (result),
        .result_valid (result_valid),
        .tx           (tx),
        .busy         (busy),
        .sent         (sent)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    int unsigned start_q[$];
    int          frame_err = 0;
    int          both_err  = 0;
    int unsigned trig_cyc;

    // Receiver: takes one sample per clock of each frame, decodes mid-bit, checks every bit is uniform.
    logic        samples[FRAME];
    int          samp_idx = 0;
    bit          in_frame = 0;
    logic [7:0]  rx_byte;

    always @(negedge clk) begin
        if (busy && sent) both_err++;
        if (!rst_n) begin
            in_frame = 0;
        end else if (!in_frame) begin
            if (tx === 1'b0) begin
                in_frame   = 1;
                samp_idx   = 0;
                samples[0] = tx;
                start_q.push_back(cyc);
            end
        end else begin
            samp_idx++;
            samples[samp_idx] = tx;
            if (samp_idx == FRAME - 1) begin
                for (int k = 0; k < 10; k++)
                    for (int j = 0; j < CPB; j++)
                        if (samples[k*CPB + j] !== samples[k*CPB + CPB/2]) frame_err++;
                if (samples[CPB/2] !== 1'b0 || samples[9*CPB + CPB/2] !== 1'b1) frame_err++;
                for (int k = 1; k <= 8; k++) rx_byte[k-1] = samples[k*CPB + CPB/2];
                rx_q.push_back(rx_byte);
                in_frame = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic build_expected(input logic [63:0] v);
        exp_q.delete();
        if (v == 0) exp_q.push_back(8'h30);
        while (v != 0) begin
            exp_q.push_front(8'h30 + 8'(v % 10));
            v = v / 10;
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        result_valid = 1'b0;
        repeat (2) @(negedge clk);
        rx_q.delete();
        start_q.delete();
        frame_err = 0;
        both_err  = 0;
        rst_n     = 1'b1;
    endtask

    task automatic wait_sent(input string tag, input int budget);
        for (int i = 0; i < budget && !sent; i++) @(negedge clk);
        check({tag, "_sent"}, sent, 1'b1);
    endtask

    task automatic compare_report(input string tag);
        int n;
        check({tag, "_len"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        for (int i = 1; i < start_q.size(); i++)
            check($sformatf("%s_gap%0d", tag, i), start_q[i] - start_q[i-1], FRAME);
        if (start_q.size() > 0)
            check({tag, "_latency_ok"}, (start_q[0] - trig_cyc) <= MAX_LAT, 1'b1);
        check({tag, "_framing"}, frame_err, 0);
        check({tag, "_busy_sent_excl"}, both_err, 0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_tx_idle"}, tx, 1'b1);
    endtask

    task automatic run_report(input logic [63:0] v, input string tag);
        do_reset();
        result = v;
        build_expected(v);
        @(negedge clk);
        result_valid = 1'b1;
        trig_cyc     = cyc;
        wait_sent(tag, (exp_q.size() + 2) * FRAME + 200);
        compare_report(tag);
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_sent", sent, 1'b0);

        run_report(64'd0, "zero");
        run_report(64'd12345, "d12345");
        run_report(64'hFFFF_FFFF_FFFF_FFFF, "max");
        run_report({$urandom, $urandom}, "rand64");
        run_report(64'($urandom), "rand32");
        run_report(64'($urandom_range(1, 999)), "rand_small");
        run_report(64'd10_000_000_000, "pow10");

        // Held valid, input changes after capture: exactly one "7\r\n".
        do_reset();
        result = 64'd7;
        build_expected(64'd7);
        @(negedge clk);
        result_valid = 1'b1;
        trig_cyc     = cyc;
        repeat (3) @(negedge clk);
        result = 64'd99;
        repeat (3 * (3 * FRAME + 100)) @(negedge clk);
        check("hold_sent", sent, 1'b1);
        compare_report("hold");
        result_valid = 1'b0;
        repeat (5) @(negedge clk);
        result_valid = 1'b1;
        repeat (300) @(negedge clk);
        check("hold_retrig_len", rx_q.size(), 3);
        check("hold_retrig_tx", tx, 1'b1);
        check("hold_retrig_sent", sent, 1'b1);

        // Reset in the 3rd data bit of the 2nd byte of 12345, then resend with valid still high.
        do_reset();
        result = 64'd12345;
        build_expected(64'd12345);
        @(negedge clk);
        result_valid = 1'b1;
        for (int i = 0; i < 400 && start_q.size() < 2; i++) @(negedge clk);
        check("mid_second_byte_seen", start_q.size() >= 2, 1'b1);
        repeat (3 * CPB + 1) @(negedge clk);
        check("mid_pre_tx", tx, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_sent", sent, 1'b0);
        repeat (3) @(negedge clk);
        rx_q.delete();
        start_q.delete();
        frame_err = 0;
        both_err  = 0;
        rst_n     = 1'b1;
        trig_cyc  = cyc;
        wait_sent("resend", (exp_q.size() + 2) * FRAME + 200);
        compare_report("resend");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
